// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI/TMDS encoder: control tokens,
// the reset symbol and an 8-bit popcount.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00    = 10'h354;
  localparam logic [9:0] TOKEN_C01    = 10'h0AB;
  localparam logic [9:0] TOKEN_C10    = 10'h154;
  localparam logic [9:0] TOKEN_C11    = 10'h2AB;
  localparam logic [9:0] RESET_SYMBOL = TOKEN_C00;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] control_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      2'b11:   t = TOKEN_C11;
      default: t = RESET_SYMBOL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS lane: registered transition minimisation followed by registered
// DC balancing with a signed running disparity, or a control token in blanking.
module tmds_channel
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       de,
  input  logic [1:0] c,
  output logic [9:0] sym
);

  logic [8:0]        q_m_d, q_m_q;
  logic              de_d, de_q;
  logic [1:0]        c_d, c_q;
  logic [3:0]        n1d;
  logic              use_xnor;
  logic [3:0]        n1;
  logic signed [4:0] bal;
  logic signed [4:0] q8x2;
  logic signed [4:0] nq8x2;
  logic              cnt_pos, cnt_neg;
  logic signed [4:0] cnt_d, cnt_q;
  logic [9:0]        sym_d, sym_q;

  // Stage 1: pick XOR/XNOR chaining to minimise transitions.
  always_comb begin
    de_d     = de;
    c_d      = c;
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && (d[0] == 1'b0));
    q_m_d    = 9'd0;
    q_m_d[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q_m_d[i] = ~(q_m_d[i-1] ^ d[i]);
      end else begin
        q_m_d[i] = q_m_d[i-1] ^ d[i];
      end
    end
    q_m_d[8] = ~use_xnor;
  end

  // Stage 2: choose inversion so the running disparity is pulled toward zero.
  always_comb begin
    n1      = popcount8(q_m_q[7:0]);
    bal     = $signed({1'b0, n1}) - $signed({1'b0, 4'd8 - n1});
    q8x2    = q_m_q[8] ? 5'sd2 : 5'sd0;
    nq8x2   = q_m_q[8] ? 5'sd0 : 5'sd2;
    cnt_pos = (cnt_q[4] == 1'b0) && (cnt_q != 5'sd0);
    cnt_neg = cnt_q[4];
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    if (!de_q) begin
      sym_d = control_token(c_q);
      cnt_d = 5'sd0;
    end else if ((cnt_q == 5'sd0) || (n1 == 4'd4)) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      if (q_m_q[8]) begin
        cnt_d = cnt_q + bal;
      end else begin
        cnt_d = cnt_q - bal;
      end
    end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + q8x2 - bal;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q - nq8x2 + bal;
    end
  end

  // Pipeline and disparity registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m_q <= 9'd0;
      de_q  <= 1'b0;
      c_q   <= 2'b00;
      sym_q <= RESET_SYMBOL;
      cnt_q <= 5'sd0;
    end else begin
      q_m_q <= q_m_d;
      de_q  <= de_d;
      c_q   <= c_d;
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// Three-lane DVI TMDS encoder: realigns the timing strobes to the pixel
// latency and feeds one tmds_channel per colour.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [9:0]  tmds_r,
  output logic [9:0]  tmds_g,
  output logic [9:0]  tmds_b
);

  logic [2:0] sync_a;
  logic       hs_a, vs_a, de_a;

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign sync_a = {hsync, vsync, de};
    end else begin : g_delay
      logic [2:0] line_d [SYNC_DELAY];
      logic [2:0] line_q [SYNC_DELAY];

      // Shift {hsync, vsync, de} down the delay line.
      always_comb begin
        line_d[0] = {hsync, vsync, de};
        for (int i = 1; i < SYNC_DELAY; i++) begin
          line_d[i] = line_q[i-1];
        end
      end

      // Delay line registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            line_q[i] <= 3'b000;
          end
        end else begin
          for (int i = 0; i < SYNC_DELAY; i++) begin
            line_q[i] <= line_d[i];
          end
        end
      end

      assign sync_a = line_q[SYNC_DELAY-1];
    end
  endgenerate

  assign hs_a = sync_a[2];
  assign vs_a = sync_a[1];
  assign de_a = sync_a[0];

  // Only the blue lane carries sync in its control bits.
  tmds_channel u_ch_b (
    .clk (clk),
    .rst (rst),
    .d   (rgb[7:0]),
    .de  (de_a),
    .c   ({vs_a, hs_a}),
    .sym (tmds_b)
  );

  tmds_channel u_ch_g (
    .clk (clk),
    .rst (rst),
    .d   (rgb[15:8]),
    .de  (de_a),
    .c   (2'b00),
    .sym (tmds_g)
  );

  tmds_channel u_ch_r (
    .clk (clk),
    .rst (rst),
    .d   (rgb[23:16]),
    .de  (de_a),
    .c   (2'b00),
    .sym (tmds_r)
  );

endmodule
